// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary pointer conversion.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned FIFO_DATASIZE = 8;

  // Only the low w bits of b take part; the result is zero above bit w-1.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] bm;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    bm   = b & mask;
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from bit w-1 down to bit 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_out_reg.sv
// First-word-fall-through output register with a valid/ready handshake.
module fwft_out_reg
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = FIFO_DATASIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pop,
  input  logic [DATASIZE-1:0] mem_rdata,
  input  logic                dout_ready,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid
);

  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  // A pop refills the register even while the current word is being accepted.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (pop) begin
      dout_d       = mem_rdata;
      dout_valid_d = 1'b1;
    end else if (dout_ready && dout_valid_q) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty flag, fill level and FWFT output stage of the async FIFO.
// Define RPTR_ALMOST_EMPTY_EN to add the registered ralmost_empty output.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = FIFO_ADDRSIZE,
  parameter int unsigned DATASIZE  = FIFO_DATASIZE,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_ALMOST_EMPTY_EN
  ,
  output logic                ralmost_empty
`endif
);

  localparam int unsigned PW = ADDRSIZE + 1;

  if (AE_THRESH > (32'd1 << ADDRSIZE)) begin : g_thresh_chk
    $error("AE_THRESH exceeds FIFO depth");
  end

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic [PW-1:0] wbin_c;
  logic          rempty_q, rempty_d;
  logic          pop_c;

  // Next pointer, empty and level all derive from the post-pop binary pointer.
  always_comb begin
    pop_c    = ~rempty_q & (~dout_valid | dout_ready);
    rbin_d   = rbin_q + PW'(pop_c);
    rptr_d   = PW'(bin2gray(32'(rbin_d), PW));
    rempty_d = (rptr_d == rq2_wptr);
    wbin_c   = PW'(gray2bin(32'(rq2_wptr), PW));
    rlevel_d = wbin_c - rbin_d;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
    end
  end

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

`ifdef RPTR_ALMOST_EMPTY_EN
  logic ralmost_empty_q, ralmost_empty_d;

  always_comb begin
    ralmost_empty_d = (32'(rlevel_d) <= AE_THRESH);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      ralmost_empty_q <= 1'b1;
    end else begin
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  assign ralmost_empty = ralmost_empty_q;
`endif

  fwft_out_reg #(
    .DATASIZE(DATASIZE)
  ) u_out (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .pop       (pop_c),
    .mem_rdata (mem_rdata),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Directed plus randomized bench for rptr_empty_fwft against a word-count reference model.
module tb_rptr_empty_fwft;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = AW + 1;
  localparam int          DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [PW-1:0] rq2_wptr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_rdata;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [PW-1:0] rlevel;
`ifdef RPTR_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  logic [DW-1:0] mem [DEPTH];

  // Reference state: words written, words popped, registered level, output register.
  int            wbin;
  int            rd;
  int            lvl;
  logic          m_v;
  logic [DW-1:0] m_dout;

  int checks   = 0;
  int failures = 0;

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] gray5(input int x);
    int m;
    m = x & 31;
    return PW'(m ^ (m >> 1));
  endfunction

  assign rq2_wptr  = gray5(wbin);
  assign mem_rdata = mem[raddr];

  rptr_empty_fwft dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .rq2_wptr     (rq2_wptr),
    .raddr        (raddr),
    .mem_rdata    (mem_rdata),
    .rptr         (rptr),
    .rempty       (rempty),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .rlevel       (rlevel)
`ifdef RPTR_ALMOST_EMPTY_EN
    ,
    .ralmost_empty(ralmost_empty)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rptr",       32'(rptr),       32'(gray5(rd)));
    chk("raddr",      32'(raddr),      32'(rd % DEPTH));
    chk("rempty",     32'(rempty),     32'(lvl == 0));
    chk("rlevel",     32'(rlevel),     32'(lvl));
    chk("dout_valid", 32'(dout_valid), 32'(m_v));
    chk("dout",       32'(dout),       32'(m_dout));
`ifdef RPTR_ALMOST_EMPTY_EN
    chk("ralmost_empty", 32'(ralmost_empty), 32'(lvl <= 2));
`endif
  endtask

  // Advance one clock: model computed from the inputs held before the edge.
  task automatic step(input bit do_chk);
    int            n_rd, n_lvl;
    logic          n_v;
    logic [DW-1:0] n_dout;
    bit            pop;
    if (!rrst_n) begin
      n_rd = 0; n_lvl = 0; n_v = 1'b0; n_dout = '0;
    end else begin
      pop    = (lvl != 0) && (!m_v || dout_ready);
      n_rd   = rd + (pop ? 1 : 0);
      n_v    = m_v;
      n_dout = m_dout;
      if (pop) begin
        n_dout = mem[rd % DEPTH];
        n_v    = 1'b1;
      end else if (dout_ready && m_v) begin
        n_v = 1'b0;
      end
      n_lvl = (wbin - n_rd) & 31;
    end
    @(posedge rclk);
    #1;
    if (!rrst_n) wbin = wbin & 31;
    rd = n_rd; lvl = n_lvl; m_v = n_v; m_dout = n_dout;
    if (do_chk) check_all();
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    if (wbin - rd < DEPTH) begin
      mem[wbin % DEPTH] = d;
      wbin++;
    end
  endtask

  initial begin
    int run, maxrun, need, iter;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd = 0; lvl = 0; m_v = 1'b0; m_dout = '0;

    // Reset held two cycles with a non-empty write pointer
    rrst_n = 1'b0; dout_ready = 1'b0; wbin = 4;
    step(1'b1);
    chk("reset_rptr", 32'(rptr), 32'd0);
    chk("reset_rempty", 32'(rempty), 32'd1);
    wbin = 0;
    step(1'b1);
    rrst_n = 1'b1;

    // Single word with the consumer stalled
    write_word(8'hA5);
    step(1'b1);
    chk("single_rempty_fall", 32'(rempty), 32'd0);
    chk("single_no_valid_yet", 32'(dout_valid), 32'd0);
    step(1'b1);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_valid", 32'(dout_valid), 32'd1);
    chk("single_rempty_rise", 32'(rempty), 32'd1);
    chk("single_rptr", 32'(rptr), 32'b00001);
    repeat (3) step(1'b1);
    chk("single_hold", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    step(1'b1);
    chk("single_accepted", 32'(dout_valid), 32'd0);
    dout_ready = 1'b0;

    // Full FIFO streamed at one word per cycle
    repeat (16) write_word(DW'($urandom));
    dout_ready = 1'b1;
    run = 0; maxrun = 0;
    step(1'b1);
    chk("stream_level_full", 32'(rlevel), 32'd16);
    repeat (20) begin
      step(1'b1);
      run    = dout_valid ? run + 1 : 0;
      maxrun = (run > maxrun) ? run : maxrun;
    end
    chk("stream_no_bubble", 32'(maxrun), 32'd16);
    chk("stream_empty_end", 32'(rempty), 32'd1);

    // Backpressure: only the first of three words moves to dout
    dout_ready = 1'b0;
    repeat (3) write_word(DW'($urandom));
    repeat (5) step(1'b1);
    chk("bp_level", 32'(rlevel), 32'd2);
    chk("bp_rptr", 32'(rptr), 32'(gray5(18)));
    dout_ready = 1'b1;
    repeat (5) step(1'b1);

    // Randomized traffic and backpressure
    repeat (400) begin
      if ($urandom_range(0, 2) != 0) write_word(DW'($urandom));
      dout_ready = ($urandom_range(0, 3) != 0);
      step(1'b1);
    end
    dout_ready = 1'b1;
    repeat (20) step(1'b1);

    // Bring the read pointer to 30, then cross the wrap with four words
    iter = 0;
    while ((rd % 32) != 30 && iter < 10) begin
      need = (30 - (rd % 32) + 32) % 32;
      repeat ((need > 8) ? 8 : need) write_word(DW'($urandom));
      repeat (12) step(1'b1);
      iter++;
    end
    chk("wrap_preload", 32'(rd % 32), 32'd30);
    dout_ready = 1'b0;
    repeat (4) write_word(DW'($urandom));
    step(1'b1);
    chk("wrap_level", 32'(rlevel), 32'd4);
    dout_ready = 1'b1;
    repeat (8) step(1'b1);
    chk("wrap_empty", 32'(rempty), 32'd1);
    chk("wrap_rptr", 32'(rptr), 32'b00011);

    // Reset while dout holds a word and five more are waiting
    dout_ready = 1'b0;
    repeat (6) write_word(DW'($urandom));
    repeat (3) step(1'b1);
    chk("mid_level5", 32'(rlevel), 32'd5);
    chk("mid_valid", 32'(dout_valid), 32'd1);
    rrst_n = 1'b0;
    step(1'b1);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_rptr", 32'(rptr), 32'd0);
    rrst_n = 1'b1;
    step(1'b1);
    chk("mid_release_level", 32'(rlevel), 32'd8);
    dout_ready = 1'b1;
    repeat (12) step(1'b1);

    repeat (200) begin
      if ($urandom_range(0, 1) != 0) write_word(DW'($urandom));
      dout_ready = ($urandom_range(0, 2) != 0);
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
